// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver: accepts one byte at a time from a sequencer
// and generates the RS/DATA setup, EN strobe, hold and execution wait timing.
module lcd_bus_driver #(
   parameter int T_POWERUP    = 450000,
   parameter int T_SETUP      = 2,
   parameter int T_EN         = 12,
   parameter int T_HOLD       = 2,
   parameter int T_WAIT_SHORT = 1100,
   parameter int T_WAIT_LONG  = 45000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       busy,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic       LCD_ON
);

   localparam logic [19:0] C_POWERUP    = 20'(T_POWERUP);
   localparam logic [19:0] C_SETUP      = 20'(T_SETUP);
   localparam logic [19:0] C_EN         = 20'(T_EN);
   localparam logic [19:0] C_HOLD       = 20'(T_HOLD);
   localparam logic [19:0] C_WAIT_SHORT = 20'(T_WAIT_SHORT);
   localparam logic [19:0] C_WAIT_LONG  = 20'(T_WAIT_LONG);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [19:0] cnt;
   logic [19:0] cnt_next;
   logic        en_next;
   logic        rs_next;
   logic [7:0]  data_next;
   logic        cnt_last;
   logic        long_cmd;

   // The counter is loaded with a phase length and the phase ends on its
   // last cycle, so every phase lasts exactly its parameter value.
   assign cnt_last = (cnt == 20'd1);

   // Clear (0x01) and home (0x02/0x03) need the long execution time; the
   // bus registers themselves hold the latched byte, so no extra copy.
   assign long_cmd = !LCD_RS && (LCD_DATA[7:2] == 6'd0);

   assign in_ready = (state == ST_IDLE);
   assign busy     = !in_ready;
   assign LCD_RW   = 1'b0;

   // State, timer and registered LCD bus; reset drops EN immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_POWERUP;
         cnt      <= C_POWERUP;
         LCD_EN   <= 1'b0;
         LCD_RS   <= 1'b0;
         LCD_DATA <= 8'h00;
         LCD_ON   <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         LCD_EN   <= en_next;
         LCD_RS   <= rs_next;
         LCD_DATA <= data_next;
         LCD_ON   <= 1'b1;
      end
   end

   // Next-state logic: each phase counts down, then loads the next phase.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      en_next    = 1'b0;
      rs_next    = LCD_RS;
      data_next  = LCD_DATA;
      case (state)
         ST_POWERUP: begin
            if (cnt_last) state_next = ST_IDLE;
            else          cnt_next   = cnt - 20'd1;
         end
         ST_IDLE: begin
            if (in_valid) begin
               state_next = ST_SETUP;
               cnt_next   = C_SETUP;
               rs_next    = in_rs;
               data_next  = in_data;
            end
         end
         ST_SETUP: begin
            if (cnt_last) begin
               state_next = ST_PULSE;
               cnt_next   = C_EN;
               en_next    = 1'b1;
            end else begin
               cnt_next = cnt - 20'd1;
            end
         end
         ST_PULSE: begin
            if (cnt_last) begin
               state_next = ST_HOLD;
               cnt_next   = C_HOLD;
            end else begin
               cnt_next = cnt - 20'd1;
               en_next  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_last) begin
               state_next = ST_WAIT;
               cnt_next   = long_cmd ? C_WAIT_LONG : C_WAIT_SHORT;
            end else begin
               cnt_next = cnt - 20'd1;
            end
         end
         ST_WAIT: begin
            if (cnt_last) state_next = ST_IDLE;
            else          cnt_next   = cnt - 20'd1;
         end
         default: begin
            state_next = ST_POWERUP;
            cnt_next   = C_POWERUP;
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shortened power-up and wait times.
module tb_lcd_bus_driver;

   localparam int P_POWERUP = 20;
   localparam int P_SETUP   = 2;
   localparam int P_EN      = 12;
   localparam int P_HOLD    = 2;
   localparam int P_SHORT   = 30;
   localparam int P_LONG    = 100;
   localparam int TOT_SHORT = P_SETUP + P_EN + P_HOLD + P_SHORT;
   localparam int TOT_LONG  = P_SETUP + P_EN + P_HOLD + P_LONG;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_rs;
   logic [7:0] in_data;
   logic       busy;
   logic [7:0] LCD_DATA;
   logic       LCD_RW;
   logic       LCD_EN;
   logic       LCD_RS;
   logic       LCD_ON;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int en_cycles = 0;
   logic en_last = 1'b0;

   lcd_bus_driver #(
      .T_POWERUP(P_POWERUP), .T_SETUP(P_SETUP), .T_EN(P_EN),
      .T_HOLD(P_HOLD), .T_WAIT_SHORT(P_SHORT), .T_WAIT_LONG(P_LONG)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_data(in_data), .busy(busy), .LCD_DATA(LCD_DATA),
      .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_ON(LCD_ON)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Count EN pulses and EN-high cycles, sampled mid-cycle.
   always @(negedge clk) begin
      if (LCD_EN && !en_last) pulses++;
      if (LCD_EN) en_cycles++;
      en_last = LCD_EN;
   end

   task automatic step_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic rs, input logic [7:0] data);
      in_valid = valid;
      in_rs    = rs;
      in_data  = data;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_busy"},  32'(busy),     32'd1);
      checkOutput({tag, "_en"},    32'(LCD_EN),   32'd0);
      checkOutput({tag, "_rs"},    32'(LCD_RS),   32'd0);
      checkOutput({tag, "_data"},  32'(LCD_DATA), 32'h00);
      checkOutput({tag, "_rw"},    32'(LCD_RW),   32'd0);
      checkOutput({tag, "_on"},    32'(LCD_ON),   32'd0);
   endtask

   // Directed sequence: power-up, data write, ignored inputs, commands,
   // back-to-back writes and reset during the EN pulse.
   initial begin
      int p0;
      logic       v_rs   [3];
      logic [7:0] v_data [3];
      int         v_tot  [3];
      v_rs[0] = 1'b0; v_data[0] = 8'h03; v_tot[0] = TOT_LONG;
      v_rs[1] = 1'b0; v_data[1] = 8'h04; v_tot[1] = TOT_SHORT;
      v_rs[2] = 1'b1; v_data[2] = 8'h02; v_tot[2] = TOT_SHORT;

      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 8'h41);
      step_cycles(3);
      check_reset_values("reset");

      // Power-up with in_valid already high.
      rst = 1'b1;
      step_cycles(1);
      checkOutput("pu_on_cycle1", 32'(LCD_ON), 32'd1);
      checkOutput("pu_ready_cycle1", 32'(in_ready), 32'd0);
      step_cycles(P_POWERUP - 2);
      checkOutput("pu_ready_before_end", 32'(in_ready), 32'd0);
      step_cycles(1);
      checkOutput("pu_ready_end", 32'(in_ready), 32'd1);
      checkOutput("pu_busy_end", 32'(busy), 32'd0);

      // Data write 0x41 accepted on this edge.
      step_cycles(1);
      applyStimulus(1'b0, 1'b1, 8'h41);
      checkOutput("w41_ready", 32'(in_ready), 32'd0);
      checkOutput("w41_busy", 32'(busy), 32'd1);
      checkOutput("w41_rs", 32'(LCD_RS), 32'd1);
      checkOutput("w41_data", 32'(LCD_DATA), 32'h41);
      checkOutput("w41_en_setup0", 32'(LCD_EN), 32'd0);
      step_cycles(1);
      checkOutput("w41_en_setup1", 32'(LCD_EN), 32'd0);
      step_cycles(1);
      checkOutput("w41_en_rise", 32'(LCD_EN), 32'd1);
      step_cycles(P_EN - 1);
      checkOutput("w41_en_last", 32'(LCD_EN), 32'd1);
      checkOutput("w41_data_pulse", 32'(LCD_DATA), 32'h41);
      step_cycles(1);
      checkOutput("w41_en_fall", 32'(LCD_EN), 32'd0);
      checkOutput("w41_rs_hold", 32'(LCD_RS), 32'd1);

      // Inputs offered during WAIT must be ignored.
      step_cycles(6);
      applyStimulus(1'b1, 1'b0, 8'hFF);
      step_cycles(3);
      applyStimulus(1'b1, 1'b0, 8'h01);
      step_cycles(3);
      applyStimulus(1'b0, 1'b0, 8'h01);
      step_cycles(4);
      checkOutput("ign_data", 32'(LCD_DATA), 32'h41);
      checkOutput("ign_rs", 32'(LCD_RS), 32'd1);
      checkOutput("ign_en", 32'(LCD_EN), 32'd0);
      step_cycles(TOT_SHORT - 31);
      checkOutput("w41_ready_before", 32'(in_ready), 32'd0);
      step_cycles(1);
      checkOutput("w41_ready_return", 32'(in_ready), 32'd1);
      checkOutput("w41_data_idle", 32'(LCD_DATA), 32'h41);
      checkOutput("w41_pulses", 32'(pulses), 32'd1);
      checkOutput("w41_en_width", 32'(en_cycles), 32'(P_EN));

      // Clear display: long wait.
      applyStimulus(1'b1, 1'b0, 8'h01);
      step_cycles(1);
      applyStimulus(1'b0, 1'b0, 8'h01);
      checkOutput("clr_rs", 32'(LCD_RS), 32'd0);
      checkOutput("clr_data", 32'(LCD_DATA), 32'h01);
      step_cycles(TOT_LONG - 1);
      checkOutput("clr_ready_before", 32'(in_ready), 32'd0);
      step_cycles(1);
      checkOutput("clr_ready_return", 32'(in_ready), 32'd1);

      // Function set 0x38: short wait.
      applyStimulus(1'b1, 1'b0, 8'h38);
      step_cycles(1);
      applyStimulus(1'b0, 1'b0, 8'h38);
      checkOutput("fs_data", 32'(LCD_DATA), 32'h38);
      step_cycles(TOT_SHORT - 1);
      checkOutput("fs_ready_before", 32'(in_ready), 32'd0);
      step_cycles(1);
      checkOutput("fs_ready_return", 32'(in_ready), 32'd1);

      // Long/short wait boundary vectors.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, v_rs[i], v_data[i]);
         step_cycles(1);
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput($sformatf("bnd%0d_data", i), 32'(LCD_DATA), 32'(v_data[i]));
         step_cycles(v_tot[i] - 1);
         checkOutput($sformatf("bnd%0d_ready_before", i), 32'(in_ready), 32'd0);
         step_cycles(1);
         checkOutput($sformatf("bnd%0d_ready_return", i), 32'(in_ready), 32'd1);
      end

      // Back-to-back 0x48 then 0x49 with in_valid held high.
      p0 = pulses;
      applyStimulus(1'b1, 1'b1, 8'h48);
      step_cycles(1);
      applyStimulus(1'b1, 1'b1, 8'h49);
      checkOutput("b2b_data1", 32'(LCD_DATA), 32'h48);
      step_cycles(TOT_SHORT - 1);
      checkOutput("b2b_ready_before", 32'(in_ready), 32'd0);
      checkOutput("b2b_data1_wait", 32'(LCD_DATA), 32'h48);
      step_cycles(1);
      checkOutput("b2b_ready_idle", 32'(in_ready), 32'd1);
      checkOutput("b2b_data1_idle", 32'(LCD_DATA), 32'h48);
      step_cycles(1);
      applyStimulus(1'b0, 1'b1, 8'h49);
      checkOutput("b2b_second_accept", 32'(in_ready), 32'd0);
      checkOutput("b2b_data2", 32'(LCD_DATA), 32'h49);
      step_cycles(TOT_SHORT - 1);
      checkOutput("b2b_ready2_before", 32'(in_ready), 32'd0);
      step_cycles(1);
      checkOutput("b2b_ready2_return", 32'(in_ready), 32'd1);
      checkOutput("b2b_pulses", 32'(pulses - p0), 32'd2);

      // Reset 5 cycles into the EN pulse.
      applyStimulus(1'b1, 1'b1, 8'h55);
      step_cycles(1);
      applyStimulus(1'b0, 1'b1, 8'h55);
      step_cycles(P_SETUP + 5);
      checkOutput("rmp_en_before", 32'(LCD_EN), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("rmp_async");
      step_cycles(2);
      check_reset_values("rmp_held");
      rst = 1'b1;
      step_cycles(1);
      checkOutput("rmp_on", 32'(LCD_ON), 32'd1);
      checkOutput("rmp_ready_cycle1", 32'(in_ready), 32'd0);
      step_cycles(P_POWERUP - 2);
      checkOutput("rmp_ready_before", 32'(in_ready), 32'd0);
      checkOutput("rmp_en_low", 32'(LCD_EN), 32'd0);
      step_cycles(1);
      checkOutput("rmp_ready_end", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 Parameter T_POWERUP, default 450000: power-on wait in clk cycles (~16 ms at 28 MHz).
REQ-002 Parameter T_SETUP, default 2: RS/DATA setup before LCD_EN rises, in cycles.
REQ-003 Parameter T_EN, default 12: LCD_EN high width, in cycles.
REQ-004 Parameter T_HOLD, default 2: RS/DATA hold after LCD_EN falls, in cycles.
REQ-005 Parameter T_WAIT_SHORT, default 1100: post-write execution wait for normal commands and data (~39 us).
REQ-006 Parameter T_WAIT_LONG, default 45000: post-write execution wait for clear and home (~1.6 ms).
REQ-007 All timing parameters SHALL be at least 1; the largest value fits a 20-bit counter.
REQ-008 clk  input  1  system clock; all logic on its rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-010 in_valid  input  1  upstream sequencer offers a byte.
REQ-011 in_ready  output  1  block accepts a byte this cycle.
REQ-012 in_rs  input  1  0 = command byte, 1 = data byte.
REQ-013 in_data  input  8  byte to write.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 LCD_DATA  output  8  HD44780 data bus.
REQ-016 LCD_RW  output  1  read/write select; always 0 (write only).
REQ-017 LCD_EN  output  1  HD44780 enable strobe.
REQ-018 LCD_RS  output  1  HD44780 register select.
REQ-019 LCD_ON  output  1  LCD power enable.

Function
REQ-020 The FSM SHALL have six states: POWERUP, IDLE, SETUP, PULSE, HOLD and WAIT; one down-counter SHALL time all states.
REQ-021 POWERUP SHALL last T_POWERUP cycles after reset release, then go to IDLE.
REQ-022 in_ready SHALL equal (state == IDLE); busy SHALL equal its complement.
REQ-023 A transfer is accepted on a rising edge where in_valid and in_ready are both 1; in_rs and in_data SHALL be latched on that edge.
REQ-024 While in_ready is 0, the inputs SHALL be ignored and nothing is queued.
REQ-025 On accept, the FSM SHALL enter SETUP and drive LCD_RS and LCD_DATA from the latched values with LCD_EN = 0, for T_SETUP cycles.
REQ-026 PULSE SHALL hold LCD_EN = 1 for exactly T_EN cycles, with RS/DATA stable.
REQ-027 HOLD SHALL hold LCD_EN = 0 for T_HOLD cycles, with RS/DATA stable.
REQ-028 WAIT SHALL last T_WAIT_LONG cycles when the latched rs = 0 and data[7:2] = 0 (0x00 to 0x03), otherwise T_WAIT_SHORT cycles; it then returns to IDLE.
REQ-029 in_ready SHALL reassert exactly T_SETUP + T_EN + T_HOLD + T_WAIT cycles after the accept edge.
REQ-030 Back-to-back transfers: in_valid held high SHALL be accepted on the first IDLE cycle, giving zero idle gap beyond one cycle.
REQ-031 LCD_DATA and LCD_RS SHALL keep their last written values in IDLE and WAIT; they change only on the cycle after an accept.
REQ-032 All LCD_* outputs SHALL be registered, with no combinational path from any input.
REQ-033 LCD_EN SHALL never be high outside PULSE, and SHALL never glitch.
REQ-034 LCD_RW SHALL be constant 0 at all times, including during reset.

Reset
REQ-035 While rst = 0, regardless of clk, the block SHALL force: state = POWERUP, counter = T_POWERUP, in_ready = 0, busy = 1, LCD_EN = 0, LCD_RS = 0, LCD_DATA = 8'h00, LCD_RW = 0, LCD_ON = 0.
REQ-036 LCD_ON SHALL go to 1 on the first rising edge after rst is released, and stay 1 until the next reset.
REQ-037 Reset asserted mid-transfer (any state, including PULSE) SHALL immediately drop LCD_EN to 0 and discard the transfer; the full power-up wait SHALL then repeat.

Verification
REQ-038 Power-up: release rst with in_valid = 1 -> in_ready stays 0 for 450000 cycles; LCD_ON = 1 from cycle 1; first accept at cycle 450000.
REQ-039 Data write: rs = 1, data 0x41 -> LCD_RS = 1 and LCD_DATA = 0x41 one cycle after accept; LCD_EN high for 12 cycles, starting 2 cycles after the drive; in_ready returns 1116 cycles after accept.
REQ-040 Clear: rs = 0, data 0x01 -> long wait; in_ready returns 45016 cycles after accept; command 0x38 returns after 1116.
REQ-041 Back-to-back: in_valid held high with bytes 0x48 then 0x49 -> second accept on the first IDLE cycle; exactly two EN pulses; bus values change only after each accept.
REQ-042 Ignored input: toggle in_valid and in_data during WAIT -> no extra EN pulse; LCD_DATA unchanged.
REQ-043 Reset mid-pulse: assert rst 5 cycles into PULSE -> LCD_EN = 0 asynchronously; all outputs at their reset values; after release, 450000 cycles elapse before in_ready goes high.
